// File: rtl/i2c_master_ctrl.sv
// Single-master I2C engine: one command becomes START, {addr,rw} byte, slave ACK,
// then one written byte (slave ACK) or one read byte (master NACK), then STOP.
module i2c_master_ctrl #(
    parameter int unsigned QTR_DIV = 4
) (
    input  logic       clock_in,
    input  logic       reset_in,
    input  logic       start_in,
    input  logic       rw_in,
    input  logic [6:0] mem_addr_in,
    input  logic [7:0] wr_data_in,
    output logic [7:0] rd_data_out,
    output logic       busy_out,
    output logic       done_out,
    output logic       ack_err_out,
    output logic       i2c_scl,
    inout  wire        i2c_sda
);

    localparam logic [15:0] DIV_MAX = 16'(QTR_DIV - 1);

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR,
        ST_ADDR_ACK,
        ST_WDATA,
        ST_WDATA_ACK,
        ST_RDATA,
        ST_RNACK,
        ST_STOP,
        ST_DONE
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] div_q, div_d;
    logic [1:0]  qtr_q, qtr_d;
    logic [2:0]  bit_cnt_q, bit_cnt_d;
    logic        rw_q, rw_d;
    logic [6:0]  addr_q, addr_d;
    logic [7:0]  wdat_q, wdat_d;
    logic [7:0]  rx_q, rx_d;
    logic [7:0]  rd_data_q, rd_data_d;
    logic        ack_err_q, ack_err_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        scl_q, scl_d;
    logic        sda_oe_q, sda_oe_d;

    logic        sda_in;
    logic        tick;
    logic        sample;
    logic        bit_end;
    logic [7:0]  tx_byte;

    assign sda_in = i2c_sda;

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        qtr_d     = qtr_q;
        bit_cnt_d = bit_cnt_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdat_d    = wdat_q;
        rx_d      = rx_q;
        rd_data_d = rd_data_q;
        ack_err_d = ack_err_q;
        tick      = (div_q == DIV_MAX);
        sample    = tick && (qtr_q == 2'd2);
        bit_end   = tick && (qtr_q == 2'd3);

        if (state_q != ST_IDLE && state_q != ST_DONE) begin
            div_d = tick ? '0 : div_q + 16'd1;
            if (tick) begin
                qtr_d = qtr_q + 2'd1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (start_in) begin
                    state_d   = ST_START;
                    rw_d      = rw_in;
                    addr_d    = mem_addr_in;
                    wdat_d    = wr_data_in;
                    ack_err_d = 1'b0;
                    div_d     = '0;
                    qtr_d     = '0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_d   = ST_ADDR;
                    bit_cnt_d = 3'd7;
                end
            end
            ST_ADDR: begin
                if (bit_end) begin
                    if (bit_cnt_q == 3'd0) state_d = ST_ADDR_ACK;
                    else                   bit_cnt_d = bit_cnt_q - 3'd1;
                end
            end
            ST_ADDR_ACK: begin
                if (sample && sda_in) ack_err_d = 1'b1;
                // ack_err_q already holds this bit's sample by the end of q3
                if (bit_end) begin
                    bit_cnt_d = 3'd7;
                    if (ack_err_q) state_d = ST_STOP;
                    else if (rw_q) state_d = ST_RDATA;
                    else           state_d = ST_WDATA;
                end
            end
            ST_WDATA: begin
                if (bit_end) begin
                    if (bit_cnt_q == 3'd0) state_d = ST_WDATA_ACK;
                    else                   bit_cnt_d = bit_cnt_q - 3'd1;
                end
            end
            ST_WDATA_ACK: begin
                if (sample && sda_in) ack_err_d = 1'b1;
                if (bit_end) state_d = ST_STOP;
            end
            ST_RDATA: begin
                if (sample) rx_d = {rx_q[6:0], sda_in};
                if (bit_end) begin
                    if (bit_cnt_q == 3'd0) state_d = ST_RNACK;
                    else                   bit_cnt_d = bit_cnt_q - 3'd1;
                end
            end
            ST_RNACK: begin
                if (bit_end) begin
                    rd_data_d = rx_q;
                    state_d   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (bit_end) state_d = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Bus pins are registered from the next state/quarter so they line up with it
        tx_byte  = (state_d == ST_ADDR) ? {addr_d, rw_d} : wdat_d;
        scl_d    = 1'b1;
        sda_oe_d = 1'b0;
        case (state_d)
            ST_START: sda_oe_d = qtr_d[1];
            ST_ADDR, ST_WDATA: begin
                scl_d    = qtr_d[1];
                sda_oe_d = ~tx_byte[bit_cnt_d];
            end
            ST_ADDR_ACK, ST_WDATA_ACK, ST_RDATA, ST_RNACK: scl_d = qtr_d[1];
            ST_STOP: begin
                scl_d    = qtr_d[1];
                sda_oe_d = (qtr_d != 2'd3);
            end
            default: begin
                scl_d    = 1'b1;
                sda_oe_d = 1'b0;
            end
        endcase
        busy_d = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d = (state_d == ST_DONE);
    end

    always_ff @(posedge clock_in or negedge reset_in) begin
        if (!reset_in) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            qtr_q     <= '0;
            bit_cnt_q <= '0;
            rw_q      <= 1'b0;
            addr_q    <= '0;
            wdat_q    <= '0;
            rx_q      <= '0;
            rd_data_q <= '0;
            ack_err_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            scl_q     <= 1'b1;
            sda_oe_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            qtr_q     <= qtr_d;
            bit_cnt_q <= bit_cnt_d;
            rw_q      <= rw_d;
            addr_q    <= addr_d;
            wdat_q    <= wdat_d;
            rx_q      <= rx_d;
            rd_data_q <= rd_data_d;
            ack_err_q <= ack_err_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            scl_q     <= scl_d;
            sda_oe_q  <= sda_oe_d;
        end
    end

    assign rd_data_out = rd_data_q;
    assign busy_out    = busy_q;
    assign done_out    = done_q;
    assign ack_err_out = ack_err_q;
    assign i2c_scl     = scl_q;
    assign i2c_sda     = sda_oe_q ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_master_ctrl.sv
// Bench for i2c_master_ctrl: behavioural slave RAM on the bus, transaction-level
// reference model feeding result/byte queues, and independent bus/done monitors.
module tb_i2c_master_ctrl;

    localparam int unsigned Q   = 4;
    localparam int          BIT = 4 * Q;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       rw = 1'b0;
    logic [6:0] addr = '0;
    logic [7:0] wdata = '0;
    logic [7:0] rd_data;
    logic       busy, done, ack_err, scl;
    wire        sda;
    logic       slv_drv = 1'b0;
    logic       slave_en = 1'b1;

    assign sda = slv_drv ? 1'b0 : 1'bz;
    pullup (sda);

    i2c_master_ctrl #(.QTR_DIV(Q)) dut (
        .clock_in   (clk),
        .reset_in   (rst_n),
        .start_in   (start),
        .rw_in      (rw),
        .mem_addr_in(addr),
        .wr_data_in (wdata),
        .rd_data_out(rd_data),
        .busy_out   (busy),
        .done_out   (done),
        .ack_err_out(ack_err),
        .i2c_scl    (scl),
        .i2c_sda    (sda)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct {
        logic [7:0] rd;
        logic       err;
        int         done_cyc;
    } res_t;
    typedef struct {
        logic [7:0] b;
        logic       ack;
    } byt_t;

    res_t res_q[$];
    byt_t byte_q[$];
    logic [7:0] mram [128];
    logic [7:0] sram [128];
    logic [7:0] m_last_rd = '0;

    // Reference model: one command -> expected bus bytes, final rd/ack_err, done cycle
    task automatic issue(input logic r, input logic [6:0] a, input logic [7:0] d,
                         input logic present, input bit commit);
        res_t e;
        byt_t bt;
        @(negedge clk);
        slave_en = present;
        if (commit) begin
            bt.b = {a, r};
            bt.ack = !present;
            byte_q.push_back(bt);
            if (present) begin
                if (r) begin
                    bt.b = mram[a];
                    bt.ack = 1'b1;
                    m_last_rd = mram[a];
                end else begin
                    bt.b = d;
                    bt.ack = 1'b0;
                    mram[a] = d;
                end
                byte_q.push_back(bt);
            end
            e.rd = m_last_rd;
            e.err = !present;
            e.done_cyc = cyc + 1 + (present ? 20 * BIT : 11 * BIT);
            res_q.push_back(e);
        end
        rw = r;
        addr = a;
        wdata = d;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!done && n < 30 * BIT) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_completes"}, int'(done), 1);
    endtask

    // Transaction-end monitor
    always @(negedge clk) begin
        res_t e;
        if (rst_n && done) begin
            if (res_q.size() == 0) begin
                chk("done_unexpected", 1, 0);
            end else begin
                e = res_q.pop_front();
                chk("rd_data", int'(rd_data), int'(e.rd));
                chk("ack_err", int'(ack_err), int'(e.err));
                chk("done_cycle", cyc, e.done_cyc);
                chk("busy_at_done", int'(busy), 0);
            end
        end
    end

    // Bus monitor: framing, byte decode, SCL period
    logic       m_sclp = 1'b1, m_sdap = 1'b1, mon_act = 1'b0;
    int         mon_n = 0, rise_cyc = -1;
    logic [7:0] mon_sr = '0;
    always @(negedge clk) begin
        byt_t bt;
        if (!rst_n) begin
            mon_act = 1'b0;
            mon_n = 0;
            rise_cyc = -1;
        end else if (m_sclp && scl && m_sdap && !sda) begin
            chk("start_framing", int'(mon_act), 0);
            mon_act = 1'b1;
            mon_n = 0;
            rise_cyc = -1;
        end else if (m_sclp && scl && !m_sdap && sda) begin
            chk("stop_framing", mon_n, 1);
            mon_act = 1'b0;
            rise_cyc = -1;
        end else if (!m_sclp && scl && mon_act) begin
            if (rise_cyc >= 0) chk("scl_period", cyc - rise_cyc, BIT);
            rise_cyc = cyc;
            if (mon_n == 8) begin
                if (byte_q.size() == 0) begin
                    chk("bus_byte_unexpected", 1, 0);
                end else begin
                    bt = byte_q.pop_front();
                    chk("bus_byte", int'(mon_sr), int'(bt.b));
                    chk("bus_ack_bit", int'(sda), int'(bt.ack));
                end
                mon_n = 0;
            end else begin
                mon_sr = {mon_sr[6:0], sda};
                mon_n++;
            end
        end
        m_sclp = scl;
        m_sdap = sda;
    end

    // Slave RAM device on the bus
    logic       s_sclp = 1'b1, s_sdap = 1'b1, s_rw = 1'b0;
    int         s_ph = 0, s_cnt = 0;
    logic [7:0] s_sr = '0, s_rd = '0;
    logic [6:0] s_addr = '0;
    always @(negedge clk) begin
        if (!rst_n) begin
            s_ph = 0;
            slv_drv = 1'b0;
        end else if (s_sclp && scl && s_sdap && !sda) begin
            s_ph = 1;
            s_cnt = 0;
            slv_drv = 1'b0;
        end else if (s_sclp && scl && !s_sdap && sda) begin
            s_ph = 0;
            slv_drv = 1'b0;
        end else if (!s_sclp && scl && s_ph != 0) begin
            if (s_cnt < 8) s_sr = {s_sr[6:0], sda};
            s_cnt++;
        end else if (s_sclp && !scl && s_ph != 0) begin
            slv_drv = 1'b0;
            if (s_cnt == 8) begin
                if (s_ph == 1) begin
                    s_addr = s_sr[7:1];
                    s_rw = s_sr[0];
                    slv_drv = slave_en;
                end else if (s_ph == 2) begin
                    sram[s_addr] = s_sr;
                    slv_drv = 1'b1;
                end
            end else if (s_cnt == 9) begin
                s_cnt = 0;
                if (s_ph == 1 && slave_en) begin
                    s_ph = s_rw ? 3 : 2;
                    if (s_rw) begin
                        s_rd = sram[s_addr];
                        slv_drv = !s_rd[7];
                    end
                end else begin
                    s_ph = 0;
                end
            end else if (s_ph == 3) begin
                slv_drv = !s_rd[7 - s_cnt];
            end
        end
        s_sclp = scl;
        s_sdap = sda;
    end

    initial begin
        #(100000 * 10);
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic       r, p;
        logic [6:0] a;
        logic [7:0] d;
        for (int i = 0; i < 128; i++) begin
            mram[i] = 8'($urandom);
            sram[i] = mram[i];
        end
        repeat (3) @(negedge clk);
        chk("reset_rd_data", int'(rd_data), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_ack_err", int'(ack_err), 0);
        chk("reset_scl", int'(scl), 1);
        chk("reset_sda", int'(sda), 1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        issue(1'b0, 7'h15, 8'hA5, 1'b1, 1'b1);
        chk("busy_after_accept", int'(busy), 1);
        wait_done("write_15");
        chk("slave_ram_15", int'(sram[7'h15]), 8'hA5);

        issue(1'b1, 7'h15, 8'h00, 1'b1, 1'b1);
        wait_done("read_15");

        issue(1'b0, 7'h40, 8'h3C, 1'b0, 1'b1);
        wait_done("no_slave");
        repeat (5) @(negedge clk);
        chk("ack_err_sticky", int'(ack_err), 1);

        // start_in pulsed mid-transaction with different fields must be ignored
        issue(1'b0, 7'h2C, 8'h71, 1'b1, 1'b1);
        repeat (48) @(negedge clk);
        rw = 1'b1;
        addr = 7'h53;
        wdata = 8'h8E;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done("ignore_start");
        repeat (20) @(negedge clk);
        chk("idle_after_ignore", int'(busy), 0);
        chk("slave_ram_2c", int'(sram[7'h2C]), 8'h71);

        issue(1'b1, 7'h2C, 8'h00, 1'b1, 1'b1);
        wait_done("read_2c");

        // reset in the middle of the address byte
        issue(1'b0, 7'h33, 8'h5A, 1'b1, 1'b0);
        repeat (99) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_scl", int'(scl), 1);
        chk("midrst_sda", int'(sda), 1);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_rd_data", int'(rd_data), 0);
        chk("midrst_done", int'(done), 0);
        m_last_rd = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(1'b0, 7'h33, 8'h5A, 1'b1, 1'b1);
        wait_done("write_after_reset");

        for (int i = 0; i < 14; i++) begin
            r = 1'($urandom_range(0, 1));
            p = ($urandom_range(0, 4) != 0);
            a = 7'($urandom);
            d = 8'($urandom);
            issue(r, a, d, p, 1'b1);
            wait_done("random");
        end

        repeat (5) @(negedge clk);
        chk("results_drained", res_q.size(), 0);
        chk("bytes_drained", byte_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
